// File: rtl/frame_descrambler_if.sv
// Serial bit-stream bundle between the bit slicer, the frame descrambler and
// the DeFEC chain.
//   ival/idata   : received hard bit and its valid strobe (toward the descrambler)
//   oval/odata   : descrambled payload bit and its valid strobe
//   osop/oeop    : first / last payload bit of a frame, qualified by oval
//   olock        : high while the descrambler holds frame lock
// master drives the received stream; slave is the descrambler.
interface frame_descrambler_if;
  logic ival;
  logic idata;
  logic oval;
  logic osop;
  logic oeop;
  logic odata;
  logic olock;

  modport master (output ival, idata, input oval, osop, oeop, odata, olock);
  modport slave  (input ival, idata, output oval, osop, oeop, odata, olock);
endinterface

// File: rtl/frame_descrambler.sv
// Receive-side frame synchroniser and additive descrambler.
// Finds the sync word in the serial stream, confirms it over several frames
// (SEARCH -> VERIFY -> LOCK, with flywheel through missed syncs), strips the
// sync field and descrambles the payload with the 12-bit LFSR that mirrors the
// TX scrambler, regenerating osop/oeop for the FEC decoder.
// Ports:
//   iclk   : clock
//   ireset : asynchronous active-low reset
//   bus    : frame_descrambler_if.slave (ival/idata in; oval/osop/oeop/odata/olock out)
// All outputs are registered one cycle after the ival/idata sample.
module frame_descrambler #(
  parameter logic [11:0] START_STATE = 12'hFFF,
  parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
  parameter int          SYNC_LEN    = 32,
  parameter int          FRAME_LEN   = 1024,
  parameter int          MAX_ERR     = 0,
  parameter int          LOCK_CNT    = 2,
  parameter int          MISS_CNT    = 3
) (
  input  logic               iclk,
  input  logic               ireset,
  frame_descrambler_if.slave bus
);

  localparam int PERIOD = SYNC_LEN + FRAME_LEN;
  localparam int CW     = $clog2(PERIOD);
  localparam int EW     = $clog2(SYNC_LEN + 1);
  localparam int HW     = $clog2(LOCK_CNT + 1);
  localparam int MW     = $clog2(MISS_CNT + 1);

  localparam logic [CW-1:0] SYNC_END   = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] PAY_START  = CW'(SYNC_LEN);
  localparam logic [CW-1:0] PAY_LAST   = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] PERIOD_END = CW'(PERIOD - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCK} state_e;

  function automatic logic psp(input logic [11:0] s);
    return s[11] ^ s[5] ^ s[3] ^ s[0];
  endfunction

  state_e              state_q, state_d;
  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]       hit_cnt_q, hit_cnt_d;
  logic [MW-1:0]       miss_cnt_q, miss_cnt_d;
  logic [11:0]         lfsr_q, lfsr_d;
  logic [11:0]         last_state_q, last_state_d;
  logic                oval_q, oval_d;
  logic                osop_q, osop_d;
  logic                oeop_q, oeop_d;
  logic                odata_q, odata_d;

  logic [SYNC_LEN-1:0] win;
  logic [EW-1:0]       err;
  logic                hit;
  logic [CW-1:0]       p;
  logic [11:0]         lfsr_adv;

  // Sync correlator: Hamming distance of the newest SYNC_LEN bits (including
  // the bit arriving now) against the sync word.
  always_comb begin : sync_cmp
    win = {sr_q, bus.idata};
    err = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      err = err + EW'(win[i] ^ SYNC_WORD[i]);
    end
    hit = (err <= EW'(MAX_ERR));
  end

  always_comb begin : next_state
    // NOTE: every _d is given its hold/idle value first, so no path through
    // the branches below leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    lfsr_d       = lfsr_q;
    last_state_d = last_state_q;
    oval_d       = 1'b0;
    osop_d       = 1'b0;
    oeop_d       = 1'b0;
    odata_d      = 1'b0;
    p            = bit_cnt_q - PAY_START;
    lfsr_adv     = {lfsr_q[10:0], psp(lfsr_q)};

    if (bus.ival) begin
      sr_d      = win[SYNC_LEN-2:0];
      bit_cnt_d = (bit_cnt_q == PERIOD_END) ? '0 : bit_cnt_q + 1'b1;

      unique case (state_q)
        ST_SEARCH: begin
          if (hit) begin
            // Align the period so the next valid bit is payload index 0.
            bit_cnt_d  = PAY_START;
            hit_cnt_d  = HW'(1);
            miss_cnt_d = '0;
            state_d    = (LOCK_CNT <= 1) ? ST_LOCK : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (bit_cnt_q == SYNC_END) begin
            if (!hit) begin
              state_d   = ST_SEARCH;
              hit_cnt_d = '0;
            end else if (hit_cnt_q + 1'b1 == HW'(LOCK_CNT)) begin
              state_d    = ST_LOCK;
              hit_cnt_d  = '0;
              miss_cnt_d = '0;
            end else begin
              hit_cnt_d = hit_cnt_q + 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (bit_cnt_q == SYNC_END) begin
            if (hit) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 1'b1 == MW'(MISS_CNT)) begin
              state_d    = ST_SEARCH;
              miss_cnt_d = '0;
              hit_cnt_d  = '0;
            end else begin
              // Flywheel: keep the frame timing and keep delivering payload.
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase

      // Payload delivery. Index 0 uses the end state of the previous frame
      // and reloads the LFSR without shifting, matching the TX scrambler.
      if (state_q != ST_SEARCH && bit_cnt_q >= PAY_START) begin
        oval_d = 1'b1;
        if (p == '0) begin
          osop_d  = 1'b1;
          odata_d = bus.idata ^ psp(last_state_q);
          lfsr_d  = START_STATE;
        end else begin
          odata_d = bus.idata ^ psp(lfsr_q);
          lfsr_d  = lfsr_adv;
          if (p == PAY_LAST) begin
            oeop_d       = 1'b1;
            last_state_d = lfsr_adv;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the _d values of the same edge regardless of statement order.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q      <= ST_SEARCH;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      lfsr_q       <= START_STATE;
      last_state_q <= START_STATE;
      oval_q       <= 1'b0;
      osop_q       <= 1'b0;
      oeop_q       <= 1'b0;
      odata_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      lfsr_q       <= lfsr_d;
      last_state_q <= last_state_d;
      oval_q       <= oval_d;
      osop_q       <= osop_d;
      oeop_q       <= oeop_d;
      odata_q      <= odata_d;
    end
  end

  assign bus.oval  = oval_q;
  assign bus.osop  = osop_q;
  assign bus.oeop  = oeop_q;
  assign bus.odata = odata_q;
  assign bus.olock = (state_q == ST_LOCK);

endmodule

// File: tb/tb_frame_descrambler.sv
// Self-checking bench for frame_descrambler.
// dut  : default parameters, driven by a TX scrambler model; expected payload
//        records are queued when bits are driven and popped when oval is seen.
// dut2 : FRAME_LEN=2, MAX_ERR=2, driven from a table of sync/payload steps.
module tb_frame_descrambler;

  localparam logic [31:0] SW    = 32'h1ACFFC1D;
  localparam int          FL    = 1024;
  localparam logic [11:0] START = 12'hFFF;

  logic iclk = 1'b0;
  logic ireset = 1'b0;
  always #5 iclk = ~iclk;

  frame_descrambler_if if1 ();
  frame_descrambler_if if2 ();

  frame_descrambler dut (.iclk(iclk), .ireset(ireset), .bus(if1));
  frame_descrambler #(.FRAME_LEN(2), .MAX_ERR(2)) dut2 (.iclk(iclk), .ireset(ireset), .bus(if2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic sop;
    logic eop;
    logic data;
    logic chk;   // compare data bit
  } exp_t;
  exp_t sb[$];

  always @(posedge iclk) begin : mon
    logic v;
    exp_t e;
    v = if1.ival;
    #1;
    if (ireset && if1.oval) begin
      check("oval_needs_ival", v, 1'b1);
      check("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("osop", if1.osop, e.sop);
        check("oeop", if1.oeop, e.eop);
        if (e.chk) check("odata", if1.odata, e.data);
      end
    end
  end

  // ---------------- TX scrambler model ----------------
  logic [11:0] tx_lfsr = START;
  logic [11:0] tx_last = START;

  function automatic logic tx_psp(input logic [11:0] s);
    return s[11] ^ s[5] ^ s[3] ^ s[0];
  endfunction

  task automatic drive1(input logic d, input int gap);
    while ($urandom_range(99) < gap) begin
      @(negedge iclk);
      if1.ival  = 1'b0;
      if1.idata = 1'($urandom_range(1));
    end
    @(negedge iclk);
    if1.ival  = 1'b1;
    if1.idata = d;
  endtask

  task automatic do_reset();
    @(negedge iclk);
    if1.ival = 1'b0;
    ireset   = 1'b0;
    repeat (2) @(negedge iclk);
    ireset  = 1'b1;
    tx_lfsr = START;
    tx_last = START;
    sb.delete();
  endtask

  // Expected payload for raw (unscrambled) zero input: the keystream from FFF.
  logic t1_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // raw=1 sends unscrambled payload (test 1). abort_at>=0 pulls reset there.
  task automatic tx_frame(input logic [31:0] mask, input bit raw, input bit rnd,
                          input bit exp_out, input int gap, input logic exp_lock,
                          input int abort_at);
    logic [31:0] w;
    logic d, s;
    w = SW ^ mask;
    for (int i = 31; i >= 0; i--) drive1(w[i], gap);
    @(posedge iclk);
    #1 check("olock_after_sync", if1.olock, exp_lock);
    for (int p = 0; p < FL; p++) begin
      if (p == abort_at) begin
        @(posedge iclk);
        #2;
        @(negedge iclk);
        if1.ival = 1'b0;
        ireset   = 1'b0;
        #1;
        check("rst_oval",  if1.oval,  1'b0);
        check("rst_osop",  if1.osop,  1'b0);
        check("rst_oeop",  if1.oeop,  1'b0);
        check("rst_odata", if1.odata, 1'b0);
        check("rst_olock", if1.olock, 1'b0);
        check("rst_sb_empty", sb.size(), 0);
        repeat (2) @(negedge iclk);
        ireset  = 1'b1;
        tx_lfsr = START;
        tx_last = START;
        return;
      end
      d = rnd ? 1'($urandom_range(1)) : 1'b0;
      if (raw) begin
        s = d;
      end else if (p == 0) begin
        s       = d ^ tx_psp(tx_last);
        tx_lfsr = START;
      end else begin
        s       = d ^ tx_psp(tx_lfsr);
        tx_lfsr = {tx_lfsr[10:0], tx_psp(tx_lfsr)};
        if (p == FL - 1) tx_last = tx_lfsr;
      end
      drive1(s, gap);
      if (exp_out)
        sb.push_back('{sop: (p == 0), eop: (p == FL - 1),
                       data: raw ? ((p < 5) ? t1_exp[p] : 1'b0) : d,
                       chk: raw ? (p < 5) : 1'b1});
    end
  endtask

  // ---------------- dut2 table ----------------
  typedef struct {
    int          prefix;   // zero bits before the sync word
    logic [31:0] mask;     // bits flipped in the sync word
    bit          out;      // payload expected
    logic        d0, d1;   // expected payload bits (input payload is 0,0)
    logic        lock;     // olock after the sync word
  } v2_t;

  task automatic drive2(input logic d);
    @(negedge iclk);
    if2.ival  = 1'b1;
    if2.idata = d;
  endtask

  initial begin
    v2_t tab [5];
    logic [31:0] w;
    tab[0] = '{8, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b0};  // 2 errors: hit
    tab[1] = '{0, 32'h8000_0101, 1'b0, 1'b0, 1'b0, 1'b0};  // 3 errors in VERIFY: miss
    tab[2] = '{8, 32'h8000_0101, 1'b0, 1'b0, 1'b0, 1'b0};  // 3 errors in SEARCH: miss
    tab[3] = '{8, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};  // clean: hit, last_state kept
    tab[4] = '{0, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 1'b1};  // 2 errors in VERIFY: lock

    if1.ival = 1'b0; if1.idata = 1'b0;
    if2.ival = 1'b0; if2.idata = 1'b0;
    repeat (3) @(negedge iclk);
    check("reset_oval",   if1.oval,  1'b0);
    check("reset_osop",   if1.osop,  1'b0);
    check("reset_oeop",   if1.oeop,  1'b0);
    check("reset_odata",  if1.odata, 1'b0);
    check("reset_olock",  if1.olock, 1'b0);
    check("reset2_oval",  if2.oval,  1'b0);
    check("reset2_olock", if2.olock, 1'b0);
    ireset = 1'b1;

    // 1: raw zero payload exposes the keystream.
    tx_frame(32'h0, 1'b1, 1'b0, 1'b1, 0, 1'b0, -1);
    do_reset();

    // 2: loopback, lock from frame 2.
    for (int k = 1; k <= 5; k++) tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 0, (k >= 2), -1);

    // 3: three corrupted syncs in LOCK, then reacquire.
    tx_frame(32'h0001_0000, 1'b0, 1'b1, 1'b1, 0, 1'b1, -1);
    tx_frame(32'h0000_0200, 1'b0, 1'b1, 1'b1, 0, 1'b1, -1);
    tx_frame(32'h4000_0000, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
    tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
    tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b1, -1);

    // 4: ~50% ival gaps.
    for (int k = 0; k < 2; k++) tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 50, 1'b1, -1);

    // 6: reset at p=500, then relock.
    tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 500);
    tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
    tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 0, 1'b1, -1);
    tx_frame(32'h0, 1'b0, 1'b1, 1'b1, 10, 1'b1, -1);
    @(negedge iclk);
    if1.ival = 1'b0;

    // 5 + FRAME_LEN=2: dut2 steps.
    for (int e = 0; e < 5; e++) begin
      repeat (tab[e].prefix) drive2(1'b0);
      w = SW ^ tab[e].mask;
      for (int i = 31; i >= 0; i--) drive2(w[i]);
      @(posedge iclk);
      #1 check($sformatf("t5_lock_%0d", e), if2.olock, tab[e].lock);
      for (int p = 0; p < 2; p++) begin
        drive2(1'b0);
        @(posedge iclk);
        #1;
        check($sformatf("t5_oval_%0d_%0d", e, p), if2.oval, tab[e].out);
        if (tab[e].out) begin
          check($sformatf("t5_osop_%0d_%0d", e, p), if2.osop, (p == 0));
          check($sformatf("t5_oeop_%0d_%0d", e, p), if2.oeop, (p == 1));
          check($sformatf("t5_odata_%0d_%0d", e, p), if2.odata, (p == 0) ? tab[e].d0 : tab[e].d1);
        end
      end
    end
    @(negedge iclk);
    if2.ival = 1'b0;

    repeat (4) @(negedge iclk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
